bp_io_dev_arbiter: RTL and testbench

Shares the uncached I/O device space (host at 0x0010_0000, cfg at 0x0020_0000, clint at 0x0030_0000) between `num_req_p` requesters. The block arbitrates round-robin and decodes the device field of the physical address. It issues one transaction at a time to the selected device and returns that device's response to the winning requester. It sits between the core-side uncached ports and the host/cfg/clint device slaves.

---
 rtl/bp_io_dev_arbiter_if.sv | 41 ++++
 rtl/bp_io_dev_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_bp_io_dev_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_io_dev_arbiter_if.sv
// bp_io_dev_arbiter_if: requester-side and device-side buses of the uncached
// I/O device arbiter. The slave modport is the arbiter's own view. The master
// modport is the view of the core ports and device slaves around it.
interface bp_io_dev_arbiter_if #(
   parameter int num_req_p     = 2,
   parameter int paddr_width_p = 40,
   parameter int data_width_p  = 64
);
   // Requester side
   logic [num_req_p-1:0]               req_v_i;
   logic [num_req_p*paddr_width_p-1:0] req_addr_i;
   logic [num_req_p-1:0]               req_we_i;
   logic [num_req_p*data_width_p-1:0]  req_data_i;
   logic [num_req_p-1:0]               req_ready_o;
   logic [num_req_p-1:0]               resp_v_o;
   logic [data_width_p-1:0]            resp_data_o;
   logic                               resp_err_o;

   // Device side: bit0 host, bit1 cfg, bit2 clint
   logic [2:0]                         dev_v_o;
   logic [19:0]                        dev_addr_o;
   logic                               dev_we_o;
   logic [data_width_p-1:0]            dev_data_o;
   logic [2:0]                         dev_ready_i;
   logic [2:0]                         dev_resp_v_i;
   logic [3*data_width_p-1:0]          dev_resp_data_i;

   modport slave (
      input  req_v_i, req_addr_i, req_we_i, req_data_i,
      input  dev_ready_i, dev_resp_v_i, dev_resp_data_i,
      output req_ready_o, resp_v_o, resp_data_o, resp_err_o,
      output dev_v_o, dev_addr_o, dev_we_o, dev_data_o
   );

   modport master (
      output req_v_i, req_addr_i, req_we_i, req_data_i,
      output dev_ready_i, dev_resp_v_i, dev_resp_data_i,
      input  req_ready_o, resp_v_o, resp_data_o, resp_err_o,
      input  dev_v_o, dev_addr_o, dev_we_o, dev_data_o
   );
endinterface

// File: rtl/bp_io_dev_arbiter.sv
// bp_io_dev_arbiter: round-robin arbiter that shares the host/cfg/clint
// uncached device space between num_req_p requesters. It has one transaction
// in flight at a time. Define BP_IO_ARB_TIMEOUT_EN to give the WAIT state a
// timeout of timeout_cycles_p cycles. On timeout the requester gets err=1 and
// data 0.
module bp_io_dev_arbiter #(
   parameter int num_req_p        = 2,
   parameter int paddr_width_p    = 40,
   parameter int data_width_p     = 64,
   parameter int timeout_cycles_p = 255
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   bp_io_dev_arbiter_if.slave     io
);
   localparam int rr_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

   state_e                    state_q, state_d;
   logic [rr_w_lp-1:0]        rr_q, rr_d;
   logic [rr_w_lp-1:0]        win_q, win_d;
   logic [2:0]                sel_q, sel_d;
   logic [2:0]                dev_v_q, dev_v_d;
   logic [19:0]               dev_addr_q, dev_addr_d;
   logic                      dev_we_q, dev_we_d;
   logic [data_width_p-1:0]   dev_data_q, dev_data_d;
   logic [num_req_p-1:0]      resp_v_q, resp_v_d;
   logic [data_width_p-1:0]   resp_data_q, resp_data_d;
   logic                      resp_err_q, resp_err_d;

`ifdef BP_IO_ARB_TIMEOUT_EN
   localparam int cnt_w_lp = (timeout_cycles_p > 1) ? $clog2(timeout_cycles_p + 1) : 1;
   logic [cnt_w_lp-1:0]       cnt_q, cnt_d;
`else
   // The timeout is compiled out, so the limit is unused in this build.
   logic unused_timeout;
   assign unused_timeout = ^timeout_cycles_p;
`endif

   logic                      found;
   logic [rr_w_lp-1:0]        winner;
   int                        scan_idx;
   logic [paddr_width_p-1:0]  win_addr;
   logic [3:0]                win_id;
   logic                      win_legal;
   logic [2:0]                win_sel;
   logic [num_req_p-1:0]      win_oh;
   logic [rr_w_lp-1:0]        rr_next;
   logic                      resp_hit;
   logic [data_width_p-1:0]   sel_resp_data;

   // Round-robin search: the first valid requester at or above rr, with wrap.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and infers a latch.
      found    = 1'b0;
      winner   = rr_q;
      scan_idx = 0;
      for (int i = 0; i < num_req_p; i++) begin
         scan_idx = int'(rr_q) + i;
         if (scan_idx >= num_req_p) scan_idx = scan_idx - num_req_p;
         if (!found && io.req_v_i[scan_idx]) begin
            found  = 1'b1;
            winner = rr_w_lp'(scan_idx);
         end
      end
   end

   assign win_addr  = io.req_addr_i[winner*paddr_width_p +: paddr_width_p];
   assign win_id    = win_addr[23:20];
   assign win_legal = ((win_addr >> 24) == '0) && (win_id >= 4'd1) && (win_id <= 4'd3);
   assign win_oh    = num_req_p'(1) << winner;
   assign rr_next   = (int'(winner) == num_req_p - 1) ? '0 : winner + 1'b1;

   // Device id to one-hot device select.
   always_comb begin
      case (win_id)
         4'd1:    win_sel = 3'b001;
         4'd2:    win_sel = 3'b010;
         4'd3:    win_sel = 3'b100;
         default: win_sel = 3'b000;
      endcase
   end

   // Response from the selected device only. Other devices are masked off.
   always_comb begin
      sel_resp_data = '0;
      for (int d = 0; d < 3; d++) begin
         if (sel_q[d]) sel_resp_data = io.dev_resp_data_i[d*data_width_p +: data_width_p];
      end
   end
   assign resp_hit = |(io.dev_resp_v_i & sel_q);

   // Accept is offered only in IDLE, and never while reset is asserted.
   assign io.req_ready_o = (state_q == ST_IDLE && found && !reset_i) ? win_oh : '0;

   // Next-state, capture and output-register logic for the four-state FSM.
   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      win_d       = win_q;
      sel_d       = sel_q;
      dev_v_d     = dev_v_q;
      dev_addr_d  = dev_addr_q;
      dev_we_d    = dev_we_q;
      dev_data_d  = dev_data_q;
      resp_v_d    = '0;
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
`ifdef BP_IO_ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               rr_d  = rr_next;
               win_d = winner;
               if (win_legal) begin
                  sel_d      = win_sel;
                  dev_v_d    = win_sel;
                  dev_addr_d = win_addr[19:0];
                  dev_we_d   = io.req_we_i[winner];
                  dev_data_d = io.req_data_i[winner*data_width_p +: data_width_p];
                  state_d    = ST_ISSUE;
               end else begin
                  // A decode error never touches a device.
                  resp_v_d    = win_oh;
                  resp_data_d = '0;
                  resp_err_d  = 1'b1;
                  state_d     = ST_RESP;
               end
            end
         end
         ST_ISSUE: begin
            if (|(io.dev_ready_i & sel_q)) begin
               dev_v_d = '0;
               state_d = ST_WAIT;
`ifdef BP_IO_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         ST_WAIT: begin
            if (resp_hit) begin
               resp_v_d    = num_req_p'(1) << win_q;
               resp_data_d = sel_resp_data;
               resp_err_d  = 1'b0;
               state_d     = ST_RESP;
            end
`ifdef BP_IO_ARB_TIMEOUT_EN
            else if (cnt_q == cnt_w_lp'(timeout_cycles_p - 1)) begin
               resp_v_d    = num_req_p'(1) << win_q;
               resp_data_d = '0;
               resp_err_d  = 1'b1;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered outputs. Reset drops any transaction in flight.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         rr_q        <= '0;
         win_q       <= '0;
         sel_q       <= '0;
         dev_v_q     <= '0;
         dev_addr_q  <= '0;
         dev_we_q    <= 1'b0;
         dev_data_q  <= '0;
         resp_v_q    <= '0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
`ifdef BP_IO_ARB_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments make every flop sample the pre-edge values, independent of statement order.
         state_q     <= state_d;
         rr_q        <= rr_d;
         win_q       <= win_d;
         sel_q       <= sel_d;
         dev_v_q     <= dev_v_d;
         dev_addr_q  <= dev_addr_d;
         dev_we_q    <= dev_we_d;
         dev_data_q  <= dev_data_d;
         resp_v_q    <= resp_v_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
`ifdef BP_IO_ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign io.dev_v_o     = dev_v_q;
   assign io.dev_addr_o  = dev_addr_q;
   assign io.dev_we_o    = dev_we_q;
   assign io.dev_data_o  = dev_data_q;
   assign io.resp_v_o    = resp_v_q;
   assign io.resp_data_o = resp_data_q;
   assign io.resp_err_o  = resp_err_q;
endmodule

// File: tb/tb_bp_io_dev_arbiter.sv
// tb_bp_io_dev_arbiter: directed bench with a scoreboard. Stimulus pushes
// expected grants, device requests and responses into queues. A monitor pops
// an entry and compares it whenever the arbiter presents that output.
module tb_bp_io_dev_arbiter;
   localparam int NR = 2;
   localparam int PW = 40;
   localparam int DW = 64;
   localparam int TO = 8;

   typedef struct {
      logic [2:0]    v;
      logic [19:0]   addr;
      logic          we;
      logic [DW-1:0] data;
   } dev_exp_t;

   // kind: 0 = device response, 1 = decode error, 2 = timeout
   typedef struct {
      logic [NR-1:0] v;
      logic [DW-1:0] data;
      logic          err;
      int            kind;
   } resp_exp_t;

   logic clk = 1'b0;
   logic reset_i;
   always #5 clk = ~clk;

   bp_io_dev_arbiter_if #(.num_req_p(NR), .paddr_width_p(PW), .data_width_p(DW)) io ();

   bp_io_dev_arbiter #(
      .num_req_p(NR), .paddr_width_p(PW), .data_width_p(DW), .timeout_cycles_p(TO)
   ) dut (
      .clk_i(clk),
      .reset_i(reset_i),
      .io(io)
   );

   int        gnt_q[$];
   dev_exp_t  dev_q[$];
   resp_exp_t resp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   int cyc = 0, acc_cnt = 0, hs_cnt = 0;
   int acc_cyc = 0, hs_cyc = 0, dresp_cyc = -100;
   logic [2:0] cur_sel = '0;
   logic [2:0] prev_dev_v = '0;

   // Device model controls
   int            ready_wait = 0;
   int            resp_wait  = 1;
   bit            dev_silent = 1'b0;
   bit            late_resp  = 1'b0;
   bit            stray      = 1'b0;
   logic [DW-1:0] resp_val   = '0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic exp_dev(input logic [2:0] v, input logic [19:0] a, input logic we, input logic [DW-1:0] d);
      dev_exp_t e;
      e.v = v; e.addr = a; e.we = we; e.data = d;
      dev_q.push_back(e);
   endtask

   task automatic exp_resp(input logic [NR-1:0] v, input logic [DW-1:0] d, input logic err, input int kind);
      resp_exp_t e;
      e.v = v; e.data = d; e.err = err; e.kind = kind;
      resp_q.push_back(e);
   endtask

   // Monitor: samples on the falling edge and checks against the scoreboard
   initial begin : monitor
      forever begin
         @(negedge clk);
         cyc++;
         if (reset_i) begin
            prev_dev_v = '0;
         end else begin
            if ((io.req_ready_o & io.req_v_i) != '0) begin
               check("grant_expected", gnt_q.size() != 0, 1'b1);
               if (gnt_q.size() != 0) begin
                  int g;
                  g = gnt_q.pop_front();
                  check("grant_onehot", io.req_ready_o, NR'(1) << g);
               end
               acc_cnt++;
               acc_cyc = cyc;
            end
            if (io.dev_v_o != '0) begin
               check("dev_expected", dev_q.size() != 0, 1'b1);
               if (dev_q.size() != 0) begin
                  if (prev_dev_v == '0) begin
                     check("dev_v_latency", cyc, acc_cyc + 1);
                     cur_sel = io.dev_v_o;
                  end
                  check("dev_v",    io.dev_v_o,    dev_q[0].v);
                  check("dev_addr", io.dev_addr_o, dev_q[0].addr);
                  check("dev_we",   io.dev_we_o,   dev_q[0].we);
                  check("dev_data", io.dev_data_o, dev_q[0].data);
                  if ((io.dev_v_o & io.dev_ready_i) != '0) begin
                     dev_q.delete(0);
                     hs_cnt++;
                     hs_cyc = cyc;
                  end
               end
            end
            if ((io.dev_resp_v_i & cur_sel) != '0) dresp_cyc = cyc;
            if (io.resp_v_o != '0) begin
               check("resp_expected", resp_q.size() != 0, 1'b1);
               if (resp_q.size() != 0) begin
                  resp_exp_t r;
                  r = resp_q.pop_front();
                  check("resp_v",    io.resp_v_o,    r.v);
                  check("resp_data", io.resp_data_o, r.data);
                  check("resp_err",  io.resp_err_o,  r.err);
                  case (r.kind)
                     0:       check("resp_latency_dev",     cyc, dresp_cyc + 1);
                     1:       check("resp_latency_decode",  cyc, acc_cyc + 1);
                     default: check("resp_latency_timeout", cyc, hs_cyc + 1 + TO);
                  endcase
               end
            end
            prev_dev_v = io.dev_v_o;
         end
      end
   end

   // Device model: accepts after ready_wait cycles, then responds after resp_wait cycles
   initial begin : device
      int d;
      io.dev_ready_i     = '0;
      io.dev_resp_v_i    = '0;
      io.dev_resp_data_i = '0;
      forever begin
         @(posedge clk); #1;
         if (!reset_i && io.dev_v_o != '0) begin
            d = io.dev_v_o[0] ? 0 : (io.dev_v_o[1] ? 1 : 2);
            repeat (ready_wait) begin @(posedge clk); #1; end
            io.dev_ready_i[d] = 1'b1;
            @(posedge clk); #1;
            io.dev_ready_i = '0;
            if (stray) begin
               io.dev_resp_v_i[1]          = 1'b1;
               io.dev_resp_data_i[DW +: DW] = 64'hBAD0_BAD0_BAD0_BAD0;
               @(posedge clk); #1;
               io.dev_resp_v_i = '0;
            end
            if (!dev_silent || late_resp) begin
               if (dev_silent) begin
                  repeat (9) begin @(posedge clk); #1; end
               end else begin
                  repeat (resp_wait) begin @(posedge clk); #1; end
               end
               io.dev_resp_v_i[d]           = 1'b1;
               io.dev_resp_data_i[d*DW +: DW] = dev_silent ? 64'hDEAD : resp_val;
               @(posedge clk); #1;
               io.dev_resp_v_i = '0;
               if (!dev_silent) resp_val++;
            end
         end
      end
   end

   task automatic issue(input int idx, input logic [PW-1:0] a, input logic we, input logic [DW-1:0] d);
      bit got;
      int n;
      got = 1'b0;
      n   = 0;
      io.req_addr_i[idx*PW +: PW] = a;
      io.req_we_i[idx]            = we;
      io.req_data_i[idx*DW +: DW] = d;
      io.req_v_i[idx]             = 1'b1;
      while (!got && n < 50) begin
         @(negedge clk);
         got = io.req_ready_o[idx];
         n++;
      end
      check("accept_in_time", got, 1'b1);
      @(posedge clk); #1;
      io.req_v_i[idx] = 1'b0;
   endtask

   task automatic wait_accepts(input int target);
      int n;
      n = 0;
      while (acc_cnt < target && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("accepts_in_time", acc_cnt >= target, 1'b1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((resp_q.size() != 0 || dev_q.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard_drained", resp_q.size() == 0 && dev_q.size() == 0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin : stim
      int start;
      io.req_v_i    = '0;
      io.req_addr_i = '0;
      io.req_we_i   = '0;
      io.req_data_i = '0;
      reset_i       = 1'b0;

      // Reset values, with a request already pending
      #2 reset_i = 1'b1;
      io.req_v_i = 2'b01;
      #1;
      check("rst_req_ready", io.req_ready_o, 2'b00);
      check("rst_dev_v",     io.dev_v_o,     3'b000);
      check("rst_resp_v",    io.resp_v_o,    2'b00);
      check("rst_resp_err",  io.resp_err_o,  1'b0);
      check("rst_dev_addr",  io.dev_addr_o,  20'h0);
      check("rst_resp_data", io.resp_data_o, 64'h0);
      io.req_v_i = '0;
      repeat (2) @(posedge clk);
      #1 reset_i = 1'b0;

      // Both requesters valid every cycle to cfg: grants 0,1,0,1
      resp_val = 64'h100;
      for (int i = 0; i < 4; i++) begin
         gnt_q.push_back(i % 2);
         exp_dev(3'b010, 20'h0, (i % 2 == 0), (i % 2 == 0) ? 64'hAAAA : 64'h5555);
         exp_resp((i % 2 == 0) ? 2'b01 : 2'b10, 64'h100 + 64'(i), 1'b0, 0);
      end
      io.req_addr_i = {40'h00_0020_0000, 40'h00_0020_0000};
      io.req_we_i   = 2'b01;
      io.req_data_i = {64'h5555, 64'hAAAA};
      start = acc_cnt;
      io.req_v_i = 2'b11;
      wait_accepts(start + 4);
      @(posedge clk); #1;
      io.req_v_i = '0;
      drain();

      // Req0 read from clint
      resp_val = 64'h1234;
      gnt_q.push_back(0);
      exp_dev(3'b100, 20'hbff8, 1'b0, 64'h0);
      exp_resp(2'b01, 64'h1234, 1'b0, 0);
      issue(0, 40'h00_0030_bff8, 1'b0, 64'h0);
      drain();

      // Decode errors from req1: bad id, then upper bits set
      gnt_q.push_back(1);
      exp_resp(2'b10, 64'h0, 1'b1, 1);
      issue(1, 40'h00_0050_0000, 1'b1, 64'hCAFE);
      drain();
      gnt_q.push_back(1);
      exp_resp(2'b10, 64'h0, 1'b1, 1);
      issue(1, 40'h01_0010_0000, 1'b1, 64'hF00D);
      drain();

      // Host stalls ready for 5 cycles; stray cfg response during WAIT
      ready_wait = 5;
      stray      = 1'b1;
      resp_val   = 64'h7777;
      gnt_q.push_back(0);
      exp_dev(3'b001, 20'h00040, 1'b1, 64'hDEAD_BEEF_0000_0001);
      exp_resp(2'b01, 64'h7777, 1'b0, 0);
      issue(0, 40'h00_0010_0040, 1'b1, 64'hDEAD_BEEF_0000_0001);
      drain();
      ready_wait = 0;
      stray      = 1'b0;

      // Reset pulsed while in WAIT: rr is 1 before the reset
      dev_silent = 1'b1;
      start = hs_cnt;
      gnt_q.push_back(0);
      exp_dev(3'b001, 20'h00008, 1'b0, 64'h0);
      issue(0, 40'h00_0010_0008, 1'b0, 64'h0);
      begin
         int n;
         n = 0;
         while (hs_cnt == start && n < 50) begin
            @(negedge clk);
            n++;
         end
         check("handshake_before_reset", hs_cnt != start, 1'b1);
      end
      @(posedge clk); #2;
      reset_i = 1'b1;
      #1;
      check("midrst_dev_v",     io.dev_v_o,     3'b000);
      check("midrst_dev_addr",  io.dev_addr_o,  20'h0);
      check("midrst_resp_v",    io.resp_v_o,    2'b00);
      check("midrst_resp_err",  io.resp_err_o,  1'b0);
      check("midrst_req_ready", io.req_ready_o, 2'b00);
      @(posedge clk); #1;
      reset_i    = 1'b0;
      dev_silent = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // After reset, rr restarts at 0: grant 0 then 1
      resp_val = 64'h200;
      gnt_q.push_back(0);
      gnt_q.push_back(1);
      exp_dev(3'b010, 20'h00010, 1'b0, 64'h11);
      exp_dev(3'b010, 20'h00010, 1'b0, 64'h22);
      exp_resp(2'b01, 64'h200, 1'b0, 0);
      exp_resp(2'b10, 64'h201, 1'b0, 0);
      io.req_addr_i = {40'h00_0020_0010, 40'h00_0020_0010};
      io.req_we_i   = 2'b00;
      io.req_data_i = {64'h22, 64'h11};
      start = acc_cnt;
      io.req_v_i = 2'b11;
      wait_accepts(start + 2);
      @(posedge clk); #1;
      io.req_v_i = '0;
      drain();

`ifdef BP_IO_ARB_TIMEOUT_EN
      // Device never answers in time; a late response arrives in WAIT cycle 10
      dev_silent = 1'b1;
      late_resp  = 1'b1;
      gnt_q.push_back(0);
      exp_dev(3'b100, 20'h0, 1'b0, 64'h0);
      exp_resp(2'b01, 64'h0, 1'b1, 2);
      issue(0, 40'h00_0030_0000, 1'b0, 64'h0);
      drain();
      repeat (6) @(posedge clk);
      #1;
      dev_silent = 1'b0;
      late_resp  = 1'b0;
`endif

      repeat (5) @(posedge clk);
      check("final_queues_empty", gnt_q.size() == 0 && dev_q.size() == 0 && resp_q.size() == 0, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1);
   end
endmodule
